// File: rtl/msrv32_pkg.sv
// Shared definitions for the RV32I program-counter generator: redirect
// encodings, controller state and the IALIGN fault helper.
package msrv32_pkg;

  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_EPC  = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_NEXT = 2'b11;

  localparam logic [31:0] DEFAULT_BOOT_ADDRESS = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

  // With IALIGN=2 bit 0 of a target is always zero, so only IALIGN=4 can fault.
  function automatic logic ialign_fault(input logic addr_bit1, input int ialign);
    return (ialign == 4) && addr_bit1;
  endfunction

endpackage

// File: rtl/msrv32_pc_gen_if.sv
// Instruction-fetch request channel between the PC generator (master) and
// the instruction memory (slave).
interface msrv32_pc_gen_if #(
  parameter int WIDTH = 32
);
  logic             fetch_valid_out;
  logic             fetch_ready_in;
  logic [WIDTH-1:0] i_addr_out;

  modport master (
    output fetch_valid_out,
    output i_addr_out,
    input  fetch_ready_in
  );

  modport slave (
    input  fetch_valid_out,
    input  i_addr_out,
    output fetch_ready_in
  );
endinterface

// File: rtl/msrv32_pc_next_sel.sv
// Combinational next-address priority mux with taken-branch alignment check.
module msrv32_pc_next_sel
  import msrv32_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] BOOT_ADDRESS = WIDTH'(DEFAULT_BOOT_ADDRESS),
  parameter int               IALIGN       = 4
) (
  input  logic [1:0]       pc_src,
  input  logic [WIDTH-1:0] epc,
  input  logic [WIDTH-1:0] trap_address,
  input  logic             branch_taken,
  input  logic [WIDTH-2:0] iaddr,
  input  logic [WIDTH-1:0] cur_addr,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_addr,
  output logic [WIDTH-1:0] seq_addr,
  output logic [WIDTH-1:0] target,
  output logic             misaligned
);

  assign target   = {iaddr, 1'b0};
  assign seq_addr = cur_addr + WIDTH'(IALIGN);

  always_comb begin
    redirect      = 1'b1;
    redirect_addr = target;
    misaligned    = 1'b0;
    case (pc_src)
      PC_BOOT: redirect_addr = BOOT_ADDRESS;
      PC_EPC:  redirect_addr = epc;
      PC_TRAP: redirect_addr = trap_address;
      default: begin
        misaligned = branch_taken & ialign_fault(target[1], IALIGN);
        redirect   = branch_taken & ~misaligned;
      end
    endcase
  end

endmodule

// File: rtl/msrv32_pc_gen.sv
// Registered PC generator: owns the PC, issues fetches over valid/ready and
// parks redirects that arrive while a fetch is still waiting for acceptance.
module msrv32_pc_gen
  import msrv32_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] BOOT_ADDRESS = WIDTH'(DEFAULT_BOOT_ADDRESS),
  parameter int               IALIGN       = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [1:0]        pc_src_in,
  input  logic [WIDTH-1:0]  epc_in,
  input  logic [WIDTH-1:0]  trap_address_in,
  input  logic              branch_taken_in,
  input  logic [WIDTH-2:0]  iaddr_in,
  input  logic              stall_in,
  msrv32_pc_gen_if.master   fetch,
  output logic [WIDTH-1:0]  pc_out,
  output logic [WIDTH-1:0]  pc_plus_4_out,
  output logic              misaligned_instr_out,
  output logic [WIDTH-1:0]  misaligned_addr_out
);

  pc_state_e        state_p0;
  logic             fetch_valid_p0;
  logic [WIDTH-1:0] i_addr_p0;
  logic [WIDTH-1:0] pc_p0;
  logic [WIDTH-1:0] pc_plus_4_p0;
  logic             mis_p0;
  logic [WIDTH-1:0] mis_addr_p0;
  logic             pending_p0;
  logic [WIDTH-1:0] pending_addr_p0;

  logic             redirect;
  logic [WIDTH-1:0] redirect_addr;
  logic [WIDTH-1:0] seq_addr;
  logic [WIDTH-1:0] target;
  logic             misaligned;
  logic             accept;
  logic             blocked;

  msrv32_pc_next_sel #(
    .WIDTH        (WIDTH),
    .BOOT_ADDRESS (BOOT_ADDRESS),
    .IALIGN       (IALIGN)
  ) u_next_sel (
    .pc_src        (pc_src_in),
    .epc           (epc_in),
    .trap_address  (trap_address_in),
    .branch_taken  (branch_taken_in),
    .iaddr         (iaddr_in),
    .cur_addr      (i_addr_p0),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .seq_addr      (seq_addr),
    .target        (target),
    .misaligned    (misaligned)
  );

  assign accept  = fetch_valid_p0 & fetch.fetch_ready_in;
  assign blocked = fetch_valid_p0 & ~fetch.fetch_ready_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_p0        <= BOOT;
      fetch_valid_p0  <= 1'b0;
      i_addr_p0       <= BOOT_ADDRESS;
      pc_p0           <= BOOT_ADDRESS;
      pc_plus_4_p0    <= BOOT_ADDRESS + WIDTH'(IALIGN);
      mis_p0          <= 1'b0;
      mis_addr_p0     <= '0;
      pending_p0      <= 1'b0;
      pending_addr_p0 <= '0;
    end else if (state_p0 == BOOT) begin
      state_p0       <= RUN;
      fetch_valid_p0 <= 1'b1;
      i_addr_p0      <= BOOT_ADDRESS;
    end else begin
      mis_p0 <= misaligned;
      if (misaligned) mis_addr_p0 <= target;
      if (accept) begin
        pc_p0        <= i_addr_p0;
        pc_plus_4_p0 <= seq_addr;
      end
      // A blocked request must stay stable, so redirects wait in the pending slot.
      if (blocked) begin
        if (redirect) begin
          pending_p0      <= 1'b1;
          pending_addr_p0 <= redirect_addr;
        end
      end else if (redirect) begin
        i_addr_p0  <= redirect_addr;
        pending_p0 <= 1'b0;
      end else if (!misaligned) begin
        if (pending_p0) begin
          i_addr_p0  <= pending_addr_p0;
          pending_p0 <= 1'b0;
        end else if (!stall_in) begin
          i_addr_p0 <= seq_addr;
        end
      end
    end
  end

  assign fetch.fetch_valid_out = fetch_valid_p0;
  assign fetch.i_addr_out      = i_addr_p0;
  assign pc_out                = pc_p0;
  assign pc_plus_4_out         = pc_plus_4_p0;
  assign misaligned_instr_out  = mis_p0;
  assign misaligned_addr_out   = mis_addr_p0;

endmodule

// File: tb/tb_msrv32_pc_gen.sv
// Bench for msrv32_pc_gen: directed scenarios plus random traffic against a
// rule-level reference model of the fetch address stream.
module tb_msrv32_pc_gen;

  localparam int          W      = 32;
  localparam logic [31:0] BOOT_A = 32'h0000_0000;

  logic        clk_in;
  logic        rst_in;
  logic [1:0]  pc_src_in;
  logic [31:0] epc_in;
  logic [31:0] trap_address_in;
  logic        branch_taken_in;
  logic [30:0] iaddr_in;
  logic        stall_in;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_4_out;
  logic        misaligned_instr_out;
  logic [31:0] misaligned_addr_out;

  msrv32_pc_gen_if #(.WIDTH(W)) fbus ();

  msrv32_pc_gen #(
    .WIDTH        (W),
    .BOOT_ADDRESS (BOOT_A),
    .IALIGN       (4)
  ) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .pc_src_in            (pc_src_in),
    .epc_in               (epc_in),
    .trap_address_in      (trap_address_in),
    .branch_taken_in      (branch_taken_in),
    .iaddr_in             (iaddr_in),
    .stall_in             (stall_in),
    .fetch                (fbus),
    .pc_out               (pc_out),
    .pc_plus_4_out        (pc_plus_4_out),
    .misaligned_instr_out (misaligned_instr_out),
    .misaligned_addr_out  (misaligned_addr_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: what the outputs should show right now.
  bit          m_boot;
  bit          m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_pc;
  logic [31:0] m_pc4;
  bit          m_mis;
  logic [31:0] m_mis_addr;
  logic [31:0] pend_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot     = 1'b1;
    m_valid    = 1'b0;
    m_addr     = BOOT_A;
    m_pc       = BOOT_A;
    m_pc4      = BOOT_A + 32'd4;
    m_mis      = 1'b0;
    m_mis_addr = 32'h0;
    pend_q.delete();
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_clock();
    logic [31:0] tgt;
    logic [31:0] dest;
    bit          is_redirect;
    bit          accepted;
    if (m_boot) begin
      m_boot  = 1'b0;
      m_valid = 1'b1;
      m_addr  = BOOT_A;
      m_mis   = 1'b0;
      return;
    end
    tgt         = {iaddr_in, 1'b0};
    accepted    = m_valid && fbus.fetch_ready_in;
    m_mis       = 1'b0;
    is_redirect = 1'b1;
    case (pc_src_in)
      2'd0:    dest = BOOT_A;
      2'd1:    dest = epc_in;
      2'd2:    dest = trap_address_in;
      default: begin
        dest        = tgt;
        is_redirect = branch_taken_in;
        if (branch_taken_in && (tgt % 4) != 0) begin
          is_redirect = 1'b0;
          m_mis       = 1'b1;
          m_mis_addr  = tgt;
        end
      end
    endcase
    if (accepted) begin
      m_pc  = m_addr;
      m_pc4 = m_addr + 32'd4;
    end
    if (m_valid && !fbus.fetch_ready_in) begin
      if (is_redirect) begin
        pend_q.delete();
        pend_q.push_back(dest);
      end
    end else if (is_redirect) begin
      m_addr = dest;
      pend_q.delete();
    end else if (m_mis) begin
      m_addr = m_addr;
    end else if (pend_q.size() > 0) begin
      m_addr = pend_q.pop_front();
    end else if (!stall_in) begin
      m_addr = m_addr + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},    {31'h0, fbus.fetch_valid_out}, {31'h0, m_valid});
    chk({tag, ".i_addr"},   fbus.i_addr_out, m_addr);
    chk({tag, ".pc"},       pc_out, m_pc);
    chk({tag, ".pc4"},      pc_plus_4_out, m_pc4);
    chk({tag, ".mis"},      {31'h0, misaligned_instr_out}, {31'h0, m_mis});
    chk({tag, ".mis_addr"}, misaligned_addr_out, m_mis_addr);
  endtask

  task automatic step(input string tag);
    model_clock();
    @(posedge clk_in);
    #1;
    check_all(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst_in              = 1'b0;
    pc_src_in           = 2'b11;
    epc_in              = 32'h0;
    trap_address_in     = 32'h0;
    branch_taken_in     = 1'b0;
    iaddr_in            = 31'h0;
    stall_in            = 1'b0;
    fbus.fetch_ready_in = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_all("reset");

    // Boot and sequential fetch
    rst_in = 1'b1;
    step("boot");
    chk("boot_addr", fbus.i_addr_out, 32'h0);
    step("seq4");
    step("seq8");
    chk("seq8_addr", fbus.i_addr_out, 32'h8);
    chk("seq8_pc4", pc_plus_4_out, 32'h8);

    // Blocked fetch with a branch parked until acceptance
    fbus.fetch_ready_in = 1'b0;
    step("blk1");
    branch_taken_in = 1'b1;
    iaddr_in        = 31'(32'h40 >> 1);
    step("blk2");
    branch_taken_in = 1'b0;
    step("blk3");
    chk("blk_hold", fbus.i_addr_out, 32'h8);
    fbus.fetch_ready_in = 1'b1;
    step("blk_acc");
    chk("pend_load", fbus.i_addr_out, 32'h40);

    // Misaligned taken branch, then trap
    branch_taken_in = 1'b1;
    iaddr_in        = 31'(32'h102 >> 1);
    step("mis");
    chk("mis_pulse", {31'h0, misaligned_instr_out}, 32'h1);
    chk("mis_addr", misaligned_addr_out, 32'h102);
    chk("mis_hold", fbus.i_addr_out, 32'h40);
    branch_taken_in = 1'b0;
    pc_src_in       = 2'b10;
    trap_address_in = 32'h1C0;
    step("trap");
    chk("trap_addr", fbus.i_addr_out, 32'h1C0);
    chk("mis_clear", {31'h0, misaligned_instr_out}, 32'h0);

    // Stall with an mret redirect in the second stalled cycle
    pc_src_in = 2'b11;
    stall_in  = 1'b1;
    step("stall1");
    pc_src_in = 2'b01;
    epc_in    = 32'h200;
    step("stall2");
    chk("epc_addr", fbus.i_addr_out, 32'h200);
    stall_in = 1'b0;

    // Wrap-around of the sequential increment
    epc_in = 32'hFFFF_FFFC;
    step("wrap_set");
    pc_src_in = 2'b11;
    step("wrap");
    chk("wrap_addr", fbus.i_addr_out, 32'h0);
    chk("wrap_pc4", pc_plus_4_out, 32'h0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      pc_src_in           = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      branch_taken_in     = ($urandom_range(0, 4) == 0);
      iaddr_in            = 31'($urandom);
      epc_in              = $urandom;
      trap_address_in     = $urandom;
      stall_in            = ($urandom_range(0, 4) == 0);
      fbus.fetch_ready_in = ($urandom_range(0, 9) < 7);
      step("rand");
    end

    // Reset while a redirect is pending behind a blocked fetch
    pc_src_in           = 2'b11;
    branch_taken_in     = 1'b0;
    stall_in            = 1'b0;
    fbus.fetch_ready_in = 1'b0;
    step("pre_rst");
    pc_src_in       = 2'b10;
    trap_address_in = 32'h300;
    step("pre_rst_pend");
    pc_src_in = 2'b11;
    #2;
    rst_in = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    chk("rst_valid", {31'h0, fbus.fetch_valid_out}, 32'h0);
    @(posedge clk_in);
    #1;
    check_all("rst_hold");
    rst_in              = 1'b1;
    fbus.fetch_ready_in = 1'b1;
    step("reboot");
    chk("reboot_addr", fbus.i_addr_out, BOOT_A);
    step("reboot_seq");
    chk("no_stale", fbus.i_addr_out, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrv32_pc_gen.md
Name: msrv32_pc_gen

Overview:
- Registered program-counter generator for the RV32I core; successor to the combinational PC mux.
- Owns the PC register and computes the next fetch address from boot, EPC, trap vector, branch/jump target or sequential increment.
- Issues fetch requests to the instruction memory over a valid/ready handshake.
- Handles pipeline stall, redirects that arrive during an unaccepted fetch, and misaligned-target detection for IALIGN 4 or 2.

Parameters:
- WIDTH, 32: address/PC width in bits.
- BOOT_ADDRESS, 32'h0000_0000: first fetch address after reset; must be IALIGN-aligned.
- IALIGN, 4: instruction alignment in bytes, 4 or 2. Selects the misalignment check and the sequential increment.

Ports:
- clk_in  input  1  core clock; all state on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- pc_src_in  input  2  redirect select: 00 boot, 01 epc, 10 trap, 11 normal flow.
- epc_in  input  WIDTH  return address for mret.
- trap_address_in  input  WIDTH  trap vector.
- branch_taken_in  input  1  taken branch/jump, valid when pc_src_in=11.
- iaddr_in  input  WIDTH-1  target bits [WIDTH-1:1]; target = {iaddr_in,1'b0}.
- stall_in  input  1  freeze PC advance.
- fetch_ready_in  input  1  imem accepts the current request.
- fetch_valid_out  output  1  fetch request valid.
- i_addr_out  output  WIDTH  fetch address.
- pc_out  output  WIDTH  address of the last accepted fetch.
- pc_plus_4_out  output  WIDTH  pc_out + IALIGN (link value).
- misaligned_instr_out  output  1  one-cycle pulse on a misaligned taken target.
- misaligned_addr_out  output  WIDTH  offending target, held until the next pulse.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - state=BOOT, i_addr_out=BOOT_ADDRESS, pc_out=BOOT_ADDRESS, pc_plus_4_out=BOOT_ADDRESS+IALIGN.
  - fetch_valid_out=0, misaligned_instr_out=0, misaligned_addr_out=0, pending=0.
- States:
  - BOOT: first clock after reset release. Drive fetch_valid_out=1 at BOOT_ADDRESS, then go to RUN.
  - RUN: normal operation.
- Request stability: while fetch_valid_out=1 and fetch_ready_in=0, i_addr_out and fetch_valid_out hold unchanged.
- Accept: an accept occurs on a cycle with fetch_valid_out & fetch_ready_in. On accept, pc_out <= i_addr_out and pc_plus_4_out <= i_addr_out + IALIGN, both with 1-cycle latency.
- Next address, in priority order:
  - pc_src 00 -> BOOT_ADDRESS.
  - pc_src 01 -> epc_in.
  - pc_src 10 -> trap_address_in.
  - pc_src 11 with branch_taken -> target.
  - pc_src 11 without branch_taken -> i_addr_out + IALIGN.
- Redirects (00/01/10, or 11 with a taken branch) are not gated by stall_in.
  - Free or accepting cycle: the redirect loads i_addr_out next cycle.
  - Blocked cycle (valid & !ready): the redirect target is captured in a pending register (pending=1), with newest overwriting. It loads on the cycle after the blocked request is accepted.
  - The pending redirect takes priority over sequential increment, but a fresh redirect in the same cycle wins.
- Sequential advance: happens only when !stall_in and (accept or fetch_valid_out=0). While stalled with no redirect, i_addr_out holds and fetch_valid_out stays 1.
- Misalignment:
  - Misaligned when IALIGN=4 and target[1]=1 with a taken branch (IALIGN=2: never, since bit 0 is forced 0).
  - The redirect is suppressed and i_addr_out holds.
  - misaligned_instr_out pulses exactly 1 cycle and misaligned_addr_out <= target.
  - The control unit is expected to follow with pc_src=10.
- Wrap-around: sequential increment is modulo 2^WIDTH, so 32'hFFFF_FFFC + 4 = 0 with no flag.
- EPC and trap values are used unmodified; alignment is the caller's responsibility.
- Reset mid-handshake: everything returns to reset values immediately and any pending redirect is discarded.

Decomposition:
- Shared package msrv32_pkg holds:
  - pc_src encodings PC_BOOT=2'b00, PC_EPC=2'b01, PC_TRAP=2'b10, PC_NEXT=2'b11.
  - State enum BOOT/RUN.
  - Default BOOT_ADDRESS.
- One natural sub-module, msrv32_pc_next_sel: the combinational priority mux plus misalignment check. It feeds the registered handshake/pending logic in the top.

Test Plan:
- Reset then release, fetch_ready_in=1, pc_src=11, no branch -> i_addr_out 0,4,8,C on consecutive cycles; pc_out lags by 1; pc_plus_4_out=pc_out+4.
- fetch_ready_in=0 for 3 cycles at addr 0x8 -> i_addr_out stays 0x8 with valid=1. A branch to 0x40 during the block is taken after accept: sequence 0x8 then 0x40.
- Branch with iaddr_in giving target 0x102, IALIGN=4 -> 1-cycle misaligned_instr_out, misaligned_addr_out=0x102, PC not redirected. Then pc_src=10, trap=0x1C0 -> i_addr_out=0x1C0.
- stall_in=1 for 2 cycles, pc_src=01, epc=0x200 in the 2nd stall cycle -> i_addr_out=0x200 next cycle despite the stall.
- PC at 0xFFFF_FFFC, sequential -> next i_addr_out=0x0000_0000.
- rst_in low while valid=1, ready=0 with a pending redirect -> immediately valid=0 and i_addr_out=BOOT_ADDRESS. After release, the first fetch is BOOT_ADDRESS and the pending target is never issued.
